llsc_mem_responder: RTL and testbench
=====================================

Name: llsc_mem_responder

Overview:
- Two-port shared-memory responder: the far end of the per-core mem_req/mem_resp interface.
- Arbitrates between two core ports, services loads, stores, LL and SC against a word-addressed backing store, and tracks one LL reservation per port.
- Sits below the per-core L1s, in place of the shared L2 in the multicore bench.
- Exposes a debug read port so benches can self-check memory contents, e.g. the shared counter.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width.
- MEM_WORDS, 4096, backing-store depth in words (power of 2).
- LATENCY, 2, cycles from request accept edge to response edge (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid[1:0]  in  2  per-port request valid
- req_ready[1:0]  out  2  per-port request ready
- req_wr[1:0]  in  2  1=write/SC, 0=read/LL
- req_atomic[1:0]  in  2  1=LL (wr=0) or SC (wr=1)
- req_addr0, req_addr1  in  ADDR_W each  byte address
- req_wdata0, req_wdata1  in  DATA_W each  write data
- resp_valid[1:0]  out  2  per-port response pulse
- resp_rdata0, resp_rdata1  out  DATA_W each  read data
- resp_sc_success[1:0]  out  2  SC result
- dbg_addr  in  ADDR_W  debug byte address
- dbg_rdata  out  DATA_W  combinational memory word at dbg_addr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; resp_valid=0, resp_rdata*=0, resp_sc_success=0.
  - Both reservations invalid; last_grant=1, so port 0 wins the first tie.
  - Memory array is not reset.
- Addressing: word index = addr[ADDR_W-1:2] modulo MEM_WORDS. addr[1:0] is ignored. Out-of-range addresses wrap.
- Handshake: valid/ready. A request must hold until ready. req_valid must not depend on req_ready.
  - req_ready[p] = (state==IDLE) && grant==p.
  - Grant: the only valid port, or, if both are valid, the port != last_grant.
  - With no valid request, req_ready is 0 on both ports.
  - Accept = req_valid[p] & req_ready[p] at a rising edge; last_grant<=p.
- Commit at the accept edge; all effects are atomic and serialized:
  - Read (wr=0, atomic=0): capture mem[idx].
  - LL (wr=0, atomic=1): capture mem[idx]; set res_valid[p]=1, res_addr[p]=idx. Overwrites any earlier reservation of p.
  - Write (wr=1, atomic=0): mem[idx]<=wdata. Clear every port's reservation whose res_addr==idx, including p's own.
  - SC (wr=1, atomic=1):
    - success = res_valid[p] && res_addr[p]==idx.
    - On success: write mem and clear all reservations matching idx.
    - On fail: no write.
    - res_valid[p] is cleared in both cases.
  - Response data: rdata = captured word for read/LL, 0 for write/SC. sc_success=1 only for a successful SC.
- FSM:
  - IDLE: on accept, go to WAIT with cnt=LATENCY-1.
  - WAIT: cnt==0 -> RESP, else cnt--.
  - RESP: resp_valid[granted port]=1 for exactly one cycle, then return to IDLE.
  - Response edge = accept edge + LATENCY. The next accept is possible at accept edge + LATENCY + 2.
- Response has no backpressure. Outside the RESP cycle, resp_valid=0. rdata and sc_success hold their last values.
- A request on the non-granted port stays pending; it is not dropped.
- Reset mid-transaction: the pending response is discarded and no resp_valid is issued. A memory write already committed at accept remains.
- dbg_rdata is combinational and reflects writes from the edge after commit.

Test Plan:
- Port0 write 0x1000<=0xDEADBEEF, then port1 read 0x1000, LATENCY=2 -> port1 resp_valid 2 cycles after its accept, rdata=0xDEADBEEF; dbg_addr=0x1000 gives 0xDEADBEEF.
- Port0 LL 0x1000 (value 5), then SC 0x1000<=6 -> sc_success=1, mem=6. A second SC without a new LL -> sc_success=0, mem stays 6.
- Both ports LL 0x1000, then both present SC in the same cycle (last_grant=1) -> port0 granted first, success, mem=new0. Port1 SC fails, mem unchanged.
- Port0 LL 0x2000, port1 plain write 0x2000<=7, port0 SC 0x2000<=9 -> port0 sc_success=0, mem=7.
- Both ports hold req_valid continuously for 6 requests -> accepts alternate 0,1,0,1,0,1, no request lost, one resp_valid per accept.
- Assert rst_n=0 during WAIT after a write accept -> no resp_valid. The write is visible on dbg_rdata after reset. Reservations are cleared, so a following SC without LL fails.
- Two-core LL/SC increment/decrement loop, 1000 iterations each on 0x1000 -> final dbg_rdata at 0x1000 = 0.

Source files
------------

// File: rtl/llsc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// llsc_mem_responder_if
// Two-port core <-> shared-memory request/response bundle.
//   req_valid/req_ready  : per-port valid/ready request handshake
//   req_wr/req_atomic    : op select (read, LL, write, SC)
//   req_addr*/req_wdata* : per-port byte address and write data
//   resp_valid           : per-port one-cycle response pulse
//   resp_rdata*          : per-port read data (held between responses)
//   resp_sc_success      : per-port SC outcome (held between responses)
// master = core side, slave = memory responder side.
// -----------------------------------------------------------------------------
interface llsc_mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_wr;
    logic [1:0]        req_atomic;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_rdata0;
    logic [DATA_W-1:0] resp_rdata1;
    logic [1:0]        resp_sc_success;

    modport master (
        output req_valid, req_wr, req_atomic,
        output req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, resp_valid, resp_rdata0, resp_rdata1, resp_sc_success
    );

    modport slave (
        input  req_valid, req_wr, req_atomic,
        input  req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, resp_valid, resp_rdata0, resp_rdata1, resp_sc_success
    );
endinterface

// File: rtl/llsc_mem_responder.sv
// -----------------------------------------------------------------------------
// llsc_mem_responder
// Shared-memory responder for two core ports. Arbitrates round-robin between
// the ports, commits loads, stores, LL and SC atomically at the accept edge
// against a word-addressed backing store, and keeps one LL reservation per
// port. Each accepted request gets exactly one resp_valid pulse LATENCY
// cycles after its accept edge.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : llsc_mem_responder_if.slave request/response bundle
//   dbg_addr    : debug byte address
//   dbg_rdata   : combinational memory word at dbg_addr
// -----------------------------------------------------------------------------
module llsc_mem_responder #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    llsc_mem_responder_if.slave  bus,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_rdata
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Backing store (never reset)
    logic [DATA_W-1:0] mem_r [MEM_WORDS];

    // Control state
    logic [1:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last_grant_r;
    logic              cur_port_r;
    logic [DATA_W-1:0] cap_rdata_r;
    logic              cap_sc_r;

    // Reservations
    logic [1:0]        res_valid_r;
    logic [IDX_W-1:0]  res_addr_r [2];

    // Registered response outputs
    logic [1:0]        resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r [2];
    logic [1:0]        resp_sc_r;

    // Combinational decode of the granted request
    logic              grant_s;
    logic              accept_s;
    logic [1:0]        ready_s;
    logic [IDX_W-1:0]  idx0_s;
    logic [IDX_W-1:0]  idx1_s;
    logic [IDX_W-1:0]  sel_idx_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_wr_s;
    logic              sel_at_s;
    logic              sc_ok_s;
    logic              mem_we_s;
    logic              is_ll_s;
    logic              is_sc_s;
    logic              unused_s;

    // Word index: byte-offset bits dropped, upper bits wrap modulo MEM_WORDS.
    assign idx0_s = bus.req_addr0[IDX_W+1:2];
    assign idx1_s = bus.req_addr1[IDX_W+1:2];

    // Address bits above the index and below the word are intentionally ignored.
    assign unused_s = ^{bus.req_addr0, bus.req_addr1, dbg_addr};

    // Round-robin grant: a tie goes to the port that did not win last time.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req_valid == 2'b11) begin
            grant_s = ~last_grant_r;
        end else if (bus.req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign accept_s = (state_r == ST_IDLE) && (bus.req_valid != 2'b00);

    // Ready only to the granted port while idle; zero when nobody asks.
    always_comb begin
        ready_s = 2'b00;
        if (accept_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = 2'b00;
        end
    end

    assign bus.req_ready = ready_s;

    // Mux out the granted port's address and data.
    always_comb begin
        sel_idx_s   = idx0_s;
        sel_wdata_s = bus.req_wdata0;
        if (grant_s) begin
            sel_idx_s   = idx1_s;
            sel_wdata_s = bus.req_wdata1;
        end else begin
            sel_idx_s   = idx0_s;
            sel_wdata_s = bus.req_wdata0;
        end
    end

    assign sel_wr_s = bus.req_wr[grant_s];
    assign sel_at_s = bus.req_atomic[grant_s];
    assign sc_ok_s  = res_valid_r[grant_s] && (res_addr_r[grant_s] == sel_idx_s);
    assign is_ll_s  = accept_s && !sel_wr_s && sel_at_s;
    assign is_sc_s  = accept_s && sel_wr_s && sel_at_s;
    // A failed SC must leave memory untouched.
    assign mem_we_s = accept_s && sel_wr_s && (!sel_at_s || sc_ok_s);

    // Backing-store write at the accept edge.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[sel_idx_s] <= sel_wdata_s;
        end
    end

    assign dbg_rdata = mem_r[dbg_addr[IDX_W+1:2]];

    // Reservation tracking: LL sets, any store to the word clears, own SC clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < 2; q++) begin
                res_valid_r[q] <= 1'b0;
                res_addr_r[q]  <= {IDX_W{1'b0}};
            end
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (is_ll_s && (grant_s == 1'(q))) begin
                    res_valid_r[q] <= 1'b1;
                    res_addr_r[q]  <= sel_idx_s;
                end else if ((mem_we_s && (res_addr_r[q] == sel_idx_s)) ||
                             (is_sc_s && (grant_s == 1'(q)))) begin
                    res_valid_r[q] <= 1'b0;
                end
            end
        end
    end

    // Accept / wait / respond sequencer with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
            cur_port_r   <= 1'b0;
            cap_rdata_r  <= {DATA_W{1'b0}};
            cap_sc_r     <= 1'b0;
            resp_valid_r <= 2'b00;
            resp_sc_r    <= 2'b00;
            for (int q = 0; q < 2; q++) begin
                resp_rdata_r[q] <= {DATA_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= 2'b00;
                    if (accept_s) begin
                        state_r      <= ST_WAIT;
                        cnt_r        <= CNT_INIT;
                        last_grant_r <= grant_s;
                        cur_port_r   <= grant_s;
                        // Stores and SCs return zero data.
                        cap_rdata_r  <= sel_wr_s ? {DATA_W{1'b0}} : mem_r[sel_idx_s];
                        cap_sc_r     <= is_sc_s && sc_ok_s;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r                  <= ST_RESP;
                        resp_valid_r[cur_port_r] <= 1'b1;
                        resp_rdata_r[cur_port_r] <= cap_rdata_r;
                        resp_sc_r[cur_port_r]    <= cap_sc_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    resp_valid_r <= 2'b00;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    resp_valid_r <= 2'b00;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid      = resp_valid_r;
    assign bus.resp_rdata0     = resp_rdata_r[0];
    assign bus.resp_rdata1     = resp_rdata_r[1];
    assign bus.resp_sc_success = resp_sc_r;

endmodule

// File: tb/tb_llsc_mem_responder.sv
module tb_llsc_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;

    always #5 clk = ~clk;

    llsc_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    llsc_mem_responder #(
        .ADDR_W(32), .DATA_W(32), .MEM_WORDS(4096), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_addr(dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

    typedef struct {
        logic        wr;
        logic        at;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_sc;
        int          acc_step;
    } req_t;

    req_t pend0[$];
    req_t pend1[$];
    req_t exp0[$];
    req_t exp1[$];
    int   acc_log[$];

    int n_assert = 0;
    int n_fail   = 0;
    int step_no  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input int p, input logic wr, input logic at,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_sc);
        req_t r;
        r.wr = wr; r.at = at; r.addr = addr; r.wdata = wdata;
        r.exp_rdata = exp_rdata; r.exp_sc = exp_sc; r.acc_step = 0;
        if (p == 0) pend0.push_back(r);
        else        pend1.push_back(r);
    endtask

    task automatic drive_heads();
        if (pend0.size() > 0) begin
            bus.req_valid[0]  = 1'b1;
            bus.req_wr[0]     = pend0[0].wr;
            bus.req_atomic[0] = pend0[0].at;
            bus.req_addr0     = pend0[0].addr;
            bus.req_wdata0    = pend0[0].wdata;
        end else begin
            bus.req_valid[0]  = 1'b0;
        end
        if (pend1.size() > 0) begin
            bus.req_valid[1]  = 1'b1;
            bus.req_wr[1]     = pend1[0].wr;
            bus.req_atomic[1] = pend1[0].at;
            bus.req_addr1     = pend1[0].addr;
            bus.req_wdata1    = pend1[0].wdata;
        end else begin
            bus.req_valid[1]  = 1'b0;
        end
    endtask

    // One clock: check responses and record accepts at negedge, then re-drive.
    task automatic step();
        req_t r;
        @(negedge clk);
        step_no++;
        for (int p = 0; p < 2; p++) begin
            if (bus.resp_valid[p]) begin
                if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
                    check($sformatf("p%0d unexpected resp", p), {31'b0, bus.resp_valid[p]}, 32'd0);
                end else begin
                    if (p == 0) r = exp0.pop_front();
                    else        r = exp1.pop_front();
                    check($sformatf("p%0d rdata", p),
                          (p == 0) ? bus.resp_rdata0 : bus.resp_rdata1, r.exp_rdata);
                    check($sformatf("p%0d sc_success", p),
                          {31'b0, bus.resp_sc_success[p]}, {31'b0, r.exp_sc});
                    check($sformatf("p%0d latency", p), step_no - r.acc_step, LAT + 1);
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (bus.req_valid[p] && bus.req_ready[p]) begin
                if (p == 0) begin
                    r = pend0.pop_front(); r.acc_step = step_no; exp0.push_back(r);
                end else begin
                    r = pend1.pop_front(); r.acc_step = step_no; exp1.push_back(r);
                end
                acc_log.push_back(p);
            end
        end
        @(posedge clk);
        #1;
        drive_heads();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        drive_heads();
        while ((pend0.size() + pend1.size() + exp0.size() + exp1.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        check("drain outstanding", pend0.size() + pend1.size() + exp0.size() + exp1.size(), 0);
        step();
        step();
    endtask

    task automatic dbg_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_rdata, exp);
    endtask

    // Two cores hammering one word with LL/SC increment and decrement.
    task automatic llsc_loop(input int iters, input int budget);
        int          done[2];
        logic        want_sc[2];
        logic        busy[2];
        logic [31:0] val[2];
        int          n = 0;
        for (int p = 0; p < 2; p++) begin
            done[p] = 0; want_sc[p] = 1'b0; busy[p] = 1'b0; val[p] = 32'd0;
        end
        while ((done[0] < iters || done[1] < iters) && n < budget) begin
            for (int p = 0; p < 2; p++) begin
                if (!busy[p] && done[p] < iters) begin
                    bus.req_valid[p]  = 1'b1;
                    bus.req_wr[p]     = want_sc[p];
                    bus.req_atomic[p] = 1'b1;
                    if (p == 0) begin bus.req_addr0 = 32'h1000; bus.req_wdata0 = val[0]; end
                    else        begin bus.req_addr1 = 32'h1000; bus.req_wdata1 = val[1]; end
                end else begin
                    bus.req_valid[p]  = 1'b0;
                end
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (bus.resp_valid[p]) begin
                    busy[p] = 1'b0;
                    if (!want_sc[p]) begin
                        val[p] = (p == 0) ? (bus.resp_rdata0 + 32'd1) : (bus.resp_rdata1 - 32'd1);
                        want_sc[p] = 1'b1;
                    end else begin
                        if (bus.resp_sc_success[p]) done[p]++;
                        want_sc[p] = 1'b0;
                    end
                end
                if (bus.req_valid[p] && bus.req_ready[p]) busy[p] = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_valid = 2'b00;
        check("llsc p0 iterations", done[0], iters);
        check("llsc p1 iterations", done[1], iters);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = 2'b00; bus.req_wr = 2'b00; bus.req_atomic = 2'b00;
        bus.req_addr0 = 32'd0; bus.req_addr1 = 32'd0;
        bus.req_wdata0 = 32'd0; bus.req_wdata1 = 32'd0;
        dbg_addr = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset resp_valid", {30'b0, bus.resp_valid}, 32'd0);
        check("reset rdata0", bus.resp_rdata0, 32'd0);
        check("reset rdata1", bus.resp_rdata1, 32'd0);
        check("reset sc", {30'b0, bus.resp_sc_success}, 32'd0);
        check("reset ready", {30'b0, bus.req_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle ready no valid", {30'b0, bus.req_ready}, 32'd0);

        // Write then read from the other port; tie goes to port 0 first.
        push_req(0, 1'b1, 1'b0, 32'h1000, 32'hDEADBEEF, 32'd0, 1'b0);
        push_req(1, 1'b0, 1'b0, 32'h1000, 32'd0, 32'hDEADBEEF, 1'b0);
        drain(50);
        check("first tie order", acc_log[0], 0);
        dbg_check("dbg 0x1000", 32'h1000, 32'hDEADBEEF);
        dbg_check("dbg low bits ignored", 32'h1003, 32'hDEADBEEF);
        dbg_check("dbg wrap", 32'h5000, 32'hDEADBEEF);

        // LL/SC success, then SC without LL fails.
        push_req(0, 1'b1, 1'b0, 32'h1000, 32'd5, 32'd0, 1'b0);
        push_req(0, 1'b0, 1'b1, 32'h1000, 32'd0, 32'd5, 1'b0);
        push_req(0, 1'b1, 1'b1, 32'h1000, 32'd6, 32'd0, 1'b1);
        push_req(0, 1'b1, 1'b1, 32'h1000, 32'd7, 32'd0, 1'b0);
        drain(80);
        dbg_check("dbg after sc", 32'h1000, 32'd6);

        // Both LL, then simultaneous SC with last_grant=1: port 0 wins.
        push_req(0, 1'b0, 1'b1, 32'h1000, 32'd0, 32'd6, 1'b0);
        drain(30);
        push_req(1, 1'b0, 1'b1, 32'h1000, 32'd0, 32'd6, 1'b0);
        drain(30);
        push_req(0, 1'b1, 1'b1, 32'h1000, 32'h100, 32'd0, 1'b1);
        push_req(1, 1'b1, 1'b1, 32'h1000, 32'h200, 32'd0, 1'b0);
        drain(50);
        dbg_check("dbg sc race", 32'h1000, 32'h100);

        // Intervening plain write from the other port kills the reservation.
        push_req(0, 1'b1, 1'b0, 32'h2000, 32'd0, 32'd0, 1'b0);
        push_req(0, 1'b0, 1'b1, 32'h2000, 32'd0, 32'd0, 1'b0);
        drain(50);
        push_req(1, 1'b1, 1'b0, 32'h2000, 32'd7, 32'd0, 1'b0);
        drain(30);
        push_req(0, 1'b1, 1'b1, 32'h2000, 32'd9, 32'd0, 1'b0);
        drain(30);
        dbg_check("dbg sc after foreign write", 32'h2000, 32'd7);

        // Continuous contention alternates grants.
        push_req(1, 1'b0, 1'b0, 32'h2000, 32'd0, 32'd7, 1'b0);
        drain(30);
        acc_log.delete();
        for (int i = 0; i < 3; i++) begin
            push_req(0, 1'b1, 1'b0, 32'h3000 + 32'(8 * i), 32'hA0 + 32'(i), 32'd0, 1'b0);
            push_req(1, 1'b1, 1'b0, 32'h3004 + 32'(8 * i), 32'hB0 + 32'(i), 32'd0, 1'b0);
        end
        drain(100);
        check("alternation accept count", acc_log.size(), 6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
            check($sformatf("alternation accept %0d", i), acc_log[i], i % 2);
        end
        dbg_check("dbg alt p0 last", 32'h3010, 32'hA2);
        dbg_check("dbg alt p1 last", 32'h3014, 32'hB2);

        // Reset during WAIT after a write accept.
        push_req(0, 1'b1, 1'b0, 32'h3100, 32'h55, 32'd0, 1'b0);
        push_req(0, 1'b0, 1'b1, 32'h3100, 32'd0, 32'h55, 1'b0);
        drain(50);
        push_req(0, 1'b1, 1'b0, 32'h3200, 32'h12345678, 32'd0, 1'b0);
        drive_heads();
        n = 0;
        while (exp0.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("accept before reset", exp0.size(), 1);
        rst_n = 1'b0;
        exp0.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no resp during reset", {30'b0, bus.resp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no resp after reset", {30'b0, bus.resp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        dbg_check("dbg write survives reset", 32'h3200, 32'h12345678);
        push_req(0, 1'b1, 1'b1, 32'h3100, 32'h99, 32'd0, 1'b0);
        drain(30);
        dbg_check("dbg sc after reset", 32'h3100, 32'h55);

        // Two-core atomic counter.
        push_req(0, 1'b1, 1'b0, 32'h1000, 32'd0, 32'd0, 1'b0);
        drain(30);
        llsc_loop(1000, 60000);
        repeat (4) @(posedge clk);
        #1;
        dbg_check("llsc counter final", 32'h1000, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
